// File: rtl/mat_pkg.sv
// Shared constants, state encoding and lane map for the 4x4 matrix-multiply datapath.
// Imported by the product generator, the summing stage and their benches.
package mat_pkg;

    localparam int N         = 4;
    localparam int DW        = 8;
    localparam int PW        = 18;
    localparam int NUM_LANES = 64;
    localparam int NUM_ELEMS = 32;
    localparam int NUM_GRPS  = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MULT,
        HOLD
    } state_t;

    // Lane carrying A[i][m]*B[m][j]; the four m-lanes of (i,j) sum to C[i][j].
    function automatic logic [5:0] lane(
        input logic [1:0] i,
        input logic [1:0] j,
        input logic [1:0] m
    );
        return {i, j, m};
    endfunction

endpackage

// File: rtl/mul_lane4.sv
// Four parallel unsigned DWxDW multipliers, zero-extended to PW-bit lanes.
// Purely combinational; one group of partial products per use.
module mul_lane4
    import mat_pkg::*;
(
    input  logic [N-1:0][DW-1:0] a,
    input  logic [N-1:0][DW-1:0] b,
    output logic [N-1:0][PW-1:0] p
);

    always_comb begin
        p = '0;
        for (int m = 0; m < N; m++) begin
            p[2'(m)] = {{(PW-2*DW){1'b0}},
                        (2*DW)'(a[2'(m)]) * (2*DW)'(b[2'(m)])};
        end
    end

endmodule

// File: rtl/mat_product_gen.sv
// Producer stage: loads A and B as a 32-byte stream, then emits all 64
// partial products A[i][m]*B[m][j] on a flat bus under a valid/ready handshake.
module mat_product_gen
    import mat_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DW-1:0]           in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_LANES*PW-1:0] prod_out,
    output logic                    prod_valid,
    input  logic                    prod_ready,
    output logic                    busy
);

    state_t                         state;
    logic [4:0]                     cnt;
    logic [4:0]                     grp;
    logic [NUM_ELEMS-1:0][DW-1:0]   elems;
    logic [NUM_LANES-1:0][PW-1:0]   lanes;
    logic [N-1:0][DW-1:0]           op_a;
    logic [N-1:0][DW-1:0]           op_b;
    logic [N-1:0][PW-1:0]           prods;
    logic                           xfer;

    assign xfer     = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign prod_out = lanes;

    // Group grp = 4i+j: row i of A against column j of B.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int m = 0; m < N; m++) begin
            op_a[2'(m)] = elems[{1'b0, grp[3:2], 2'(m)}];
            op_b[2'(m)] = elems[{1'b1, 2'(m), grp[1:0]}];
        end
    end

    mul_lane4 u_mul (
        .a (op_a),
        .b (op_b),
        .p (prods)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            grp        <= '0;
            in_ready   <= 1'b0;
            prod_valid <= 1'b0;
            elems      <= '0;
            lanes      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        elems[0] <= in_data;
                        cnt      <= 5'd1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        elems[cnt] <= in_data;
                        cnt        <= cnt + 5'd1;
                        if (cnt == 5'(NUM_ELEMS - 1)) begin
                            state    <= MULT;
                            grp      <= '0;
                            in_ready <= 1'b0;
                        end
                    end
                end
                MULT: begin
                    // grp == 16 is the closing cycle after the last lane write.
                    if (grp == 5'(NUM_GRPS)) begin
                        state      <= HOLD;
                        prod_valid <= 1'b1;
                    end else begin
                        for (int m = 0; m < N; m++) begin
                            lanes[lane(grp[3:2], grp[1:0], 2'(m))] <= prods[2'(m)];
                        end
                        grp <= grp + 5'd1;
                    end
                end
                HOLD: begin
                    if (prod_ready) begin
                        prod_valid <= 1'b0;
                        in_ready   <= 1'b1;
                        cnt        <= '0;
                        grp        <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_product_gen.sv
// Randomised self-checking bench for mat_product_gen against a plain
// matrix-arithmetic model of A and B.
module tb_mat_product_gen;
    import mat_pkg::*;

    logic                    clk;
    logic                    reset_n;
    logic [DW-1:0]           in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_LANES*PW-1:0] prod_out;
    logic                    prod_valid;
    logic                    prod_ready;
    logic                    busy;

    int n_chk;
    int n_fail;
    int a_m [4][4];
    int b_m [4][4];

    mat_product_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .prod_out   (prod_out),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        logic rdy;
        int   t;
        in_data  = b;
        in_valid = 1'b1;
        t        = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!rdy && t < 200);
        if (!rdy) check("push_timeout", 32'(rdy), 32'd1);
        in_valid = 1'b0;
    endtask

    function automatic logic [7:0] byte_at(input int k);
        if (k < 16) return 8'(a_m[k / 4][k % 4]);
        return 8'(b_m[(k - 16) / 4][(k - 16) % 4]);
    endfunction

    task automatic load(input bit gaps);
        for (int k = 0; k < NUM_ELEMS; k++) begin
            push(byte_at(k));
            if (gaps && k < NUM_ELEMS - 1) begin
                @(posedge clk);
                #1;
                if (k == 30) check("gap_still_loading", 32'(in_ready), 32'd1);
            end
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 5) check({tag, "_mult_in_ready"}, 32'(in_ready), 32'd0);
        end while (!prod_valid && n < 100);
        check({tag, "_latency"}, 32'(n), 32'd17);
    endtask

    task automatic check_lanes(input string tag);
        int exp;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int m = 0; m < 4; m++) begin
                    exp = a_m[i][m] * b_m[m][j];
                    check($sformatf("%s_lane%0d", tag, 16*i + 4*j + m),
                          32'(prod_out[(16*i + 4*j + m)*PW +: PW]), 32'(exp));
                end
    endtask

    task automatic check_c(input string tag);
        int c, s;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                c = 0;
                s = 0;
                for (int m = 0; m < 4; m++) c += a_m[i][m] * b_m[m][j];
                for (int m = 0; m < 4; m++)
                    s += int'(prod_out[(4*(4*i + j) + m)*PW +: PW]);
                check($sformatf("%s_c%0d%0d", tag, i, j), 32'(s), 32'(c));
            end
    endtask

    task automatic handshake(input string tag);
        prod_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_hs_valid"}, 32'(prod_valid), 32'd0);
        check({tag, "_hs_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_hs_busy"}, 32'(busy), 32'd0);
        prod_ready = 1'b0;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = int'($urandom_range(0, 255));
                b_m[r][c] = int'($urandom_range(0, 255));
            end
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = v;
                b_m[r][c] = v;
            end
    endtask

    initial begin
        logic [NUM_LANES*PW-1:0] snap;
        n_chk      = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        prod_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_valid", 32'(prod_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_prod_zero", 32'(|prod_out), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Identity A, B[r][c] = 4r+c+1
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = (r == c) ? 1 : 0;
                b_m[r][c] = 4*r + c + 1;
            end
        load(1'b0);
        wait_valid("ident");
        check("ident_busy", 32'(busy), 32'd1);
        check_lanes("ident");
        handshake("ident");

        // All 0xFF: maximum product, top lane bits stay clear
        fill_const(255);
        load(1'b0);
        wait_valid("ff");
        check_lanes("ff");
        check("ff_hi_bits", 32'(prod_out[17:16]), 32'd0);
        handshake("ff");

        // Gapped load, then a 10-cycle downstream stall
        fill_rand();
        load(1'b1);
        wait_valid("gap");
        check_lanes("gap");
        snap = prod_out;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk);
            #1;
            check("stall_valid", 32'(prod_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_stable", 32'(prod_out == snap), 32'd1);
        end
        handshake("stall");

        // Abort a load after byte 20, then a fresh all-2 load
        fill_rand();
        for (int k = 0; k <= 20; k++) push(byte_at(k));
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(prod_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        fill_const(2);
        load(1'b0);
        wait_valid("two");
        check_lanes("two");
        handshake("two");

        // Back-to-back pairs with prod_ready tied high
        prod_ready = 1'b1;
        fill_rand();
        load(1'b0);
        wait_valid("b2b1");
        check_lanes("b2b1");
        fill_rand();
        load(1'b0);
        wait_valid("b2b2");
        check_lanes("b2b2");
        check_c("b2b2");
        prod_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
